// File: rtl/zyy_seg_capture.sv
// zyy_seg_capture
// Reads back the multiplexed 8-digit seven-segment bus of the game-time
// display. Each scanned digit is decoded and stored. A complete, clean frame
// is converted from BCD to binary by a shift/subtract-3 engine that runs one
// step per clock. The result is presented with valid and change pulses.
module zyy_seg_capture #(
    parameter int DIGITS = 8
) (
    input  logic              clk_1000,
    input  logic              rst,
    input  logic [DIGITS-1:0] law,
    input  logic [6:0]        oData,
    output logic [31:0]       value,
    output logic              value_valid,
    output logic              value_chg,
    output logic              frame_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t            state;
    logic [3:0]        digit [DIGITS];
    logic [DIGITS-1:0] seen;
    logic              bad;
    logic [31:0]       conv_bcd;
    logic [31:0]       conv_bin;
    logic [4:0]        iter;

    logic [DIGITS-1:0] sel;
    logic              sel_one;
    logic [IDX_W-1:0]  sel_idx;
    logic [3:0]        seg_digit;
    logic              seg_ok;
    logic              frame_full;
    logic              frame_bad;
    logic              load;
    logic [DIGITS-1:0] seen_nx;
    logic              bad_nx;
    logic [31:0]       load_bcd;
    logic [63:0]       shifted;
    logic [31:0]       step_bcd;

    // Digit select: exactly one low bit of law picks the slot being scanned.
    // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel     = ~law;
        sel_one = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
    end

    // Segment pattern to decimal digit; anything else is flagged invalid.
    always_comb begin
        seg_ok    = 1'b1;
        seg_digit = 4'd0;
        case (oData)
            7'b1000000: seg_digit = 4'd0;
            7'b1111001: seg_digit = 4'd1;
            7'b0100100: seg_digit = 4'd2;
            7'b0110000: seg_digit = 4'd3;
            7'b0011001: seg_digit = 4'd4;
            7'b0010010: seg_digit = 4'd5;
            7'b0000010: seg_digit = 4'd6;
            7'b1111000: seg_digit = 4'd7;
            7'b0000000: seg_digit = 4'd8;
            7'b0010000: seg_digit = 4'd9;
            default:    seg_ok    = 1'b0;
        endcase
    end

    // Frame bookkeeping: a full frame either errors out or loads the engine.
    // A sample on the same edge as a clear starts the next frame's tracking.
    always_comb begin
        frame_full = (seen == '1);
        frame_bad  = frame_full && bad;
        load       = frame_full && !bad && (state == S_IDLE);
        seen_nx    = seen;
        bad_nx     = bad;
        if (frame_bad || load) begin
            seen_nx = '0;
            bad_nx  = 1'b0;
        end
        if (sel_one) begin
            seen_nx[sel_idx] = 1'b1;
            bad_nx           = bad_nx | !seg_ok;
        end
        load_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_bcd[4*i +: 4] = digit[i];
        end
    end

    // One conversion step: shift right, then subtract 3 from every nibble >= 8.
    always_comb begin
        shifted  = {conv_bcd, conv_bin} >> 1;
        step_bcd = shifted[63:32];
        for (int i = 0; i < DIGITS; i++) begin
            if (step_bcd[4*i +: 4] >= 4'd8) step_bcd[4*i +: 4] = step_bcd[4*i +: 4] - 4'd3;
        end
    end

    // Capture registers: digit store, seen/bad tracking and the frame error pulse.
    // NOTE: the digit store is reset explicitly because a reset must discard any partial frame.
    always_ff @(posedge clk_1000 or negedge rst) begin
        if (!rst) begin
            seen      <= '0;
            bad       <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < DIGITS; i++) digit[i] <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            seen      <= seen_nx;
            bad       <= bad_nx;
            frame_err <= frame_bad;
            if (sel_one) digit[sel_idx] <= seg_digit;
        end
    end

    // Conversion engine FSM with registered result, valid and change outputs.
    always_ff @(posedge clk_1000 or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            conv_bcd    <= '0;
            conv_bin    <= '0;
            iter        <= '0;
            busy        <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            value_chg   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            value_chg   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        conv_bcd <= load_bcd;
                        conv_bin <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    conv_bcd <= step_bcd;
                    conv_bin <= shifted[31:0];
                    iter     <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        value       <= shifted[31:0];
                        value_valid <= 1'b1;
                        value_chg   <= (shifted[31:0] != value);
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zyy_seg_capture.sv
// tb_zyy_seg_capture
// Self-checking bench: directed scenarios plus randomized frames, compared
// every cycle against a behavioural model that converts frames with plain
// decimal arithmetic and tracks conversion latency as a countdown.
`timescale 1ns/1ps
module tb_zyy_seg_capture;

    logic        clk_1000 = 1'b0;
    logic        rst;
    logic [7:0]  law;
    logic [6:0]  oData;
    logic [31:0] value;
    logic        value_valid;
    logic        value_chg;
    logic        frame_err;
    logic        busy;

    zyy_seg_capture #(.DIGITS(8)) dut (
        .clk_1000    (clk_1000),
        .rst         (rst),
        .law         (law),
        .oData       (oData),
        .value       (value),
        .value_valid (value_valid),
        .value_chg   (value_chg),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk_1000 = ~clk_1000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // ---------------- reference model ----------------
    int          m_digit [8];
    bit [7:0]    m_seen;
    bit          m_bad;
    int          m_busy_cnt;
    int unsigned m_pending;
    int unsigned m_value;
    bit          m_valid, m_chg, m_err;

    int cyc = 0;
    int n_valid = 0;
    int n_valid_nochg = 0;
    int n_err = 0;
    int busy_hi = 0;

    function automatic int model_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) if (seg_tbl[d] == s) return d;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_digit[k] = 0;
        m_seen = '0; m_bad = 0; m_busy_cnt = 0; m_pending = 0;
        m_value = 0; m_valid = 0; m_chg = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic [7:0] l, input logic [6:0] s);
        bit was_busy;
        int zeros, idx, d;
        was_busy = (m_busy_cnt > 0);
        m_valid = 0; m_chg = 0; m_err = 0;
        if (was_busy) begin
            m_busy_cnt--;
            if (m_busy_cnt == 0) begin
                m_valid = 1;
                m_chg   = (m_pending != m_value);
                m_value = m_pending;
            end
        end
        if (m_seen == 8'hFF) begin
            if (m_bad) begin
                m_err = 1; m_seen = '0; m_bad = 0;
            end else if (!was_busy) begin
                m_pending = 0;
                for (int k = 7; k >= 0; k--) m_pending = m_pending * 10 + m_digit[k];
                m_busy_cnt = 32;
                m_seen = '0;
            end
        end
        zeros = 0; idx = 0;
        for (int k = 0; k < 8; k++) if (l[k] == 1'b0) begin zeros++; idx = k; end
        if (zeros == 1) begin
            d = model_decode(s);
            m_digit[idx] = (d < 0) ? 0 : d;
            m_seen[idx]  = 1'b1;
            if (d < 0) m_bad = 1;
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "value"}, value, m_value);
        check({pfx, "value_valid"}, 32'(value_valid), 32'(m_valid));
        check({pfx, "value_chg"}, 32'(value_chg), 32'(m_chg));
        check({pfx, "frame_err"}, 32'(frame_err), 32'(m_err));
        check({pfx, "busy"}, 32'(busy), 32'(m_busy_cnt > 0));
    endtask

    // One clock: drive inputs away from the edge, update the model, compare.
    task automatic step(input logic [7:0] l, input logic [6:0] s);
        law = l; oData = s;
        @(posedge clk_1000);
        model_edge(l, s);
        #1;
        cyc++;
        if (value_valid) begin n_valid++; if (!value_chg) n_valid_nochg++; end
        if (frame_err) n_err++;
        if (busy) busy_hi++;
        check_outputs("cyc_");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'hFF, 7'h7F);
    endtask

    function automatic logic [6:0] digit_seg(input int unsigned n, input int k);
        int unsigned q;
        q = n;
        for (int i = 0; i < k; i++) q = q / 10;
        return seg_tbl[q % 10];
    endfunction

    // Scans slots 0..7 of n; bad_slot >= 0 blanks that slot. e0 = slot-7 edge.
    task automatic scan_frame(input int unsigned n, input int bad_slot, input bit with_idle, output int e0);
        logic [7:0] l;
        logic [6:0] s;
        for (int k = 0; k < 8; k++) begin
            l = ~(8'(1) << k);
            s = (k == bad_slot) ? 7'h7F : digit_seg(n, k);
            step(l, s);
        end
        e0 = cyc;
        if (with_idle) idle(1);
    endtask

    // Waits (bounded) for value_valid and checks latency and result.
    task automatic wait_result(input string tag, input int e0, input int unsigned exp);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (value_valid) found = 1;
            else idle(1);
        end
        check({tag, "_seen_valid"}, 32'(found), 32'd1);
        check({tag, "_latency"}, 32'(cyc - e0), 32'd33);
        check({tag, "_value"}, value, exp);
    endtask

    initial begin
        int e0;
        int v0, nv, ne;
        int ord [8];
        int tmp, j;
        int unsigned n;
        logic [6:0] s;

        rst = 1'b0; law = 8'hFF; oData = 7'h7F;
        model_reset();
        #12;
        check("reset_value", value, 32'd0);
        check("reset_valid", 32'(value_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        @(negedge clk_1000);
        rst = 1'b1;
        @(posedge clk_1000); #1;

        // Clean frame 00000123
        nv = n_valid;
        scan_frame(123, -1, 1, e0);
        wait_result("clean123", e0, 123);
        check("clean123_chg", 32'(value_chg), 32'd1);
        idle(3);
        check("clean123_one_valid", 32'(n_valid - nv), 32'd1);

        // Bad digit in slot 4
        nv = n_valid; ne = n_err;
        scan_frame(45678, 4, 1, e0);
        idle(40);
        check("bad_err_pulses", 32'(n_err - ne), 32'd1);
        check("bad_no_valid", 32'(n_valid - nv), 32'd0);
        check("bad_value_held", value, 32'd123);
        scan_frame(4321, -1, 1, e0);
        wait_result("after_bad", e0, 4321);
        idle(2);

        // Maximum value with busy-length measurement
        busy_hi = 0;
        scan_frame(99999999, -1, 1, e0);
        wait_result("max", e0, 32'h05F5E0FF);
        idle(2);
        check("max_busy_len", 32'(busy_hi), 32'd32);

        // Select errors interleaved with a clean frame of 5
        for (int k = 0; k < 8; k++) begin
            step(8'hFF, seg_tbl[3]);
            step(8'b1111_1100, seg_tbl[7]);
            step(~(8'(1) << k), digit_seg(5, k));
        end
        e0 = cyc;
        idle(1);
        wait_result("selerr", e0, 5);

        // Back-to-back: 5 then continuous 6 frames
        idle(2);
        nv = n_valid_nochg;
        scan_frame(5, -1, 1, e0);
        idle(3);
        check("b2b_same_no_chg", 32'(value_chg), 32'd0);
        for (int f = 0; f < 10; f++) scan_frame(6, -1, 0, e0);
        idle(40);
        check("b2b_value", value, 32'd6);
        check("b2b_repeat_nochg", 32'(n_valid_nochg - nv > 1), 32'd1);

        // Reset in the middle of a conversion (during step 10)
        scan_frame(77, -1, 1, e0);
        idle(10);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst_");
        #2;
        rst = 1'b1;
        @(posedge clk_1000); #1;
        check_outputs("postrst_");
        scan_frame(42, -1, 1, e0);
        wait_result("after_rst", e0, 42);
        check("after_rst_chg", 32'(value_chg), 32'd1);

        // Randomized frames: random digits, slot order, junk selects, bad segments, gaps
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(99999999, 0);
            for (int k = 0; k < 8; k++) ord[k] = k;
            for (int k = 7; k > 0; k--) begin
                j = $urandom_range(k, 0);
                tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
            end
            v0 = $urandom_range(9, 0);
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(9, 0) == 0) step(8'($urandom) | 8'h81 & 8'hFF, seg_tbl[$urandom_range(9, 0)]);
                s = digit_seg(n, ord[k]);
                if (v0 == 0 && k == 3) s = 7'($urandom) | 7'h01;
                step(~(8'(1) << ord[k]), s);
            end
            idle($urandom_range(45, 0));
        end
        idle(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
